// File: rtl/mult_pipe_ctrl.sv
// Two-stage valid/ready N x N multiplier (signed or unsigned operands) with flush.
// Define MULT_PIPE_CNT_EN to enable the 16-bit completed-output counter on ops_count.
module mult_pipe_ctrl #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic [15:0]    ops_count
);

  // Unsigned shift-and-add array multiplier, one partial-product row per multiplier bit.
  function automatic logic [2*N-1:0] array_mult(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [2*N-1:0] acc;
    logic [2*N-1:0] row;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      row = y[i] ? ({{N{1'b0}}, x} << i) : '0;
      acc = acc + row;
    end
    return acc;
  endfunction

  logic           s1_valid;
  logic [N-1:0]   s1_amag;
  logic [N-1:0]   s1_bmag;
  logic           s1_neg;

  logic           s2_load;
  logic           s1_adv;
  logic           in_fire;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic           neg_in;
  logic [2*N-1:0] mult_res;
  logic [2*N-1:0] prod_next;

  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_load;
  assign in_ready = !flush && (!s1_valid || s1_adv);
  assign in_fire  = in_valid && in_ready;

  // Negating 0x80 wraps back to 0x80, which read as unsigned is the correct magnitude 128.
  assign a_mag  = (is_signed && a[N-1]) ? -a : a;
  assign b_mag  = (is_signed && b[N-1]) ? -b : b;
  assign neg_in = is_signed && (a[N-1] ^ b[N-1]);

  assign mult_res  = array_mult(s1_amag, s1_bmag);
  assign prod_next = s1_neg ? -mult_res : mult_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_amag  <= '0;
      s1_bmag  <= '0;
      s1_neg   <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_amag <= a_mag;
        s1_bmag <= b_mag;
        s1_neg  <= neg_in;
      end
      if (in_fire)
        s1_valid <= 1'b1;
      else if (s1_adv)
        s1_valid <= 1'b0;
    end
  end

  // Product only changes when a new result moves in, so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      product   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid)
        product <= prod_next;
    end
  end

`ifdef MULT_PIPE_CNT_EN
  logic [15:0] cnt_q;

  // Counts every output handshake, including one that coincides with a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= 16'h0000;
    else if (out_valid && out_ready)
      cnt_q <= cnt_q + 16'd1;
  end

  assign ops_count = cnt_q;
`else
  assign ops_count = 16'h0000;
`endif

endmodule
